// File: rtl/wfg_wb_interconnect.sv
`default_nettype none
// ============================================================================
// Module   : wfg_wb_interconnect
// Purpose  : Wishbone classic 1-to-N interconnect. Page-decoded, one registered
//            transfer at a time, with bus-error reporting and fault capture.
//            Optional REQ timeout: define WFG_WB_INTERCONNECT_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wfg_wb_interconnect #(
  parameter int BUSW           = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int PAGE_LSB       = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                       io_wbs_clk,
  input  logic                       io_wbs_rst,
  input  logic                       io_wbs_cyc,
  input  logic                       io_wbs_stb,
  input  logic                       io_wbs_we,
  input  logic [BUSW-1:0]            io_wbs_adr,
  input  logic [BUSW-1:0]            io_wbs_datwr,
  output logic [BUSW-1:0]            io_wbs_datrd,
  output logic                       io_wbs_ack,
  output logic                       io_wbs_err,
  output logic                       s_cyc_o,
  output logic                       s_we_o,
  output logic [PAGE_LSB-1:0]        s_adr_o,
  output logic [BUSW-1:0]            s_datwr_o,
  output logic [NUM_SLAVES-1:0]      s_stb_o,
  input  logic [NUM_SLAVES-1:0]      s_ack_i,
  input  logic [NUM_SLAVES*BUSW-1:0] s_datrd_i,
  output logic [BUSW-1:0]            err_adr_o,
  output logic [7:0]                 err_cnt_o
);

  localparam int PW = BUSW - PAGE_LSB;
  localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    cyc_q, cyc_d;
  logic                    we_q, we_d;
  logic [PAGE_LSB-1:0]     adr_q, adr_d;
  logic [BUSW-1:0]         datwr_q, datwr_d;
  logic [NUM_SLAVES-1:0]   stb_q, stb_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [BUSW-1:0]         datrd_q, datrd_d;
  logic [BUSW-1:0]         err_adr_q, err_adr_d;
  logic [7:0]              err_cnt_q, err_cnt_d;

  logic [BUSW-1:0]         slice [NUM_SLAVES];
  logic [PW-1:0]           page;
  logic                    page_valid;
  logic [IW-1:0]           page_idx;
  logic                    sel_ack;
  logic [7:0]              err_cnt_inc;

  if (TIMEOUT_CYCLES < 1) begin : g_tmo_chk
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slice
    assign slice[gi] = s_datrd_i[gi*BUSW +: BUSW];
  end

  assign page        = io_wbs_adr[BUSW-1:PAGE_LSB];
  assign page_valid  = (page != '0) && (page <= PW'(NUM_SLAVES));
  assign page_idx    = IW'(page - PW'(1));
  assign sel_ack     = s_ack_i[idx_q];
  assign err_cnt_inc = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

`ifdef WFG_WB_INTERCONNECT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [BUSW-1:0] hadr_q, hadr_d;
  logic            tmo_hit;
  // Expiry is the last REQ cycle; an ack sampled in that same cycle still wins.
  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    datwr_d   = datwr_q;
    stb_d     = stb_q;
    idx_d     = idx_q;
    datrd_d   = datrd_q;
    err_adr_d = err_adr_q;
    err_cnt_d = err_cnt_q;
`ifdef WFG_WB_INTERCONNECT_TIMEOUT_EN
    tmo_d     = tmo_q;
    hadr_d    = hadr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (io_wbs_cyc && io_wbs_stb) begin
          if (page_valid) begin
            state_d = REQ;
            cyc_d   = 1'b1;
            we_d    = io_wbs_we;
            adr_d   = io_wbs_adr[PAGE_LSB-1:0];
            datwr_d = io_wbs_datwr;
            idx_d   = page_idx;
            stb_d   = NUM_SLAVES'(1) << page_idx;
`ifdef WFG_WB_INTERCONNECT_TIMEOUT_EN
            tmo_d   = '0;
            hadr_d  = io_wbs_adr;
`endif
          end else begin
            state_d   = ERR;
            err_adr_d = io_wbs_adr;
            err_cnt_d = err_cnt_inc;
          end
        end
      end
      REQ: begin
        if (!io_wbs_cyc) begin
          state_d = IDLE;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          adr_d   = '0;
          datwr_d = '0;
          stb_d   = '0;
        end else if (sel_ack) begin
          state_d = RESP;
          datrd_d = slice[idx_q];
          cyc_d   = 1'b0;
          stb_d   = '0;
        end
`ifdef WFG_WB_INTERCONNECT_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d   = ERR;
          cyc_d     = 1'b0;
          stb_d     = '0;
          err_adr_d = hadr_q;
          err_cnt_d = err_cnt_inc;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge io_wbs_clk or posedge io_wbs_rst) begin
    if (io_wbs_rst) begin
      state_q   <= IDLE;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      datwr_q   <= '0;
      stb_q     <= '0;
      idx_q     <= '0;
      datrd_q   <= '0;
      err_adr_q <= '0;
      err_cnt_q <= '0;
`ifdef WFG_WB_INTERCONNECT_TIMEOUT_EN
      tmo_q     <= '0;
      hadr_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      datwr_q   <= datwr_d;
      stb_q     <= stb_d;
      idx_q     <= idx_d;
      datrd_q   <= datrd_d;
      err_adr_q <= err_adr_d;
      err_cnt_q <= err_cnt_d;
`ifdef WFG_WB_INTERCONNECT_TIMEOUT_EN
      tmo_q     <= tmo_d;
      hadr_q    <= hadr_d;
`endif
    end
  end

  assign io_wbs_ack   = (state_q == RESP);
  assign io_wbs_err   = (state_q == ERR);
  assign io_wbs_datrd = datrd_q;
  assign s_cyc_o      = cyc_q;
  assign s_we_o       = we_q;
  assign s_adr_o      = adr_q;
  assign s_datwr_o    = datwr_q;
  assign s_stb_o      = stb_q;
  assign err_adr_o    = err_adr_q;
  assign err_cnt_o    = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_wfg_wb_interconnect.sv
`default_nettype none
// ============================================================================
// Module   : tb_wfg_wb_interconnect
// Purpose  : Transaction-level bench for wfg_wb_interconnect: directed cases
//            plus randomized accesses against a page/latency reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wfg_wb_interconnect;

  localparam int BUSW = 32;
  localparam int NS   = 4;
  localparam int PLSB = 4;
  localparam int TMO  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              cyc, stb, we;
  logic [BUSW-1:0]   adr, datwr;
  logic [BUSW-1:0]   datrd;
  logic              ack, err;
  logic              s_cyc, s_we;
  logic [PLSB-1:0]   s_adr;
  logic [BUSW-1:0]   s_datwr;
  logic [NS-1:0]     s_stb;
  logic [NS-1:0]     s_ack;
  logic [NS*BUSW-1:0] s_datrd;
  logic [BUSW-1:0]   err_adr;
  logic [7:0]        err_cnt;

  int              n_checks = 0;
  int              n_errors = 0;
  int              cnt_m    = 0;
  logic [BUSW-1:0] eadr_m   = '0;
  logic [BUSW-1:0] slv_data [NS];

  always #5 clk = ~clk;

  wfg_wb_interconnect #(
    .BUSW(BUSW), .NUM_SLAVES(NS), .PAGE_LSB(PLSB), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .io_wbs_clk(clk), .io_wbs_rst(rst), .io_wbs_cyc(cyc), .io_wbs_stb(stb),
    .io_wbs_we(we), .io_wbs_adr(adr), .io_wbs_datwr(datwr),
    .io_wbs_datrd(datrd), .io_wbs_ack(ack), .io_wbs_err(err),
    .s_cyc_o(s_cyc), .s_we_o(s_we), .s_adr_o(s_adr), .s_datwr_o(s_datwr),
    .s_stb_o(s_stb), .s_ack_i(s_ack), .s_datrd_i(s_datrd),
    .err_adr_o(err_adr), .err_cnt_o(err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_slaves();
    for (int k = 0; k < NS; k++) s_datrd[k*BUSW +: BUSW] = slv_data[k];
  endtask

  // One host access; slave acks wait_cyc cycles after the strobe first appears.
  task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input int wait_cyc);
    int            page;
    logic [NS-1:0] oh;
    page = int'(a >> PLSB);
    load_slaves();
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; datwr = d;
    tick();
    if (page < 1 || page > NS) begin
      if (cnt_m < 255) cnt_m++;
      eadr_m = a;
      check("err_pulse", 32'(err), 1);
      check("err_noack", 32'(ack), 0);
      check("err_nostb", 32'(s_stb), 0);
      check("err_nocyc", 32'(s_cyc), 0);
      check("err_adr",   err_adr, eadr_m);
      check("err_cnt",   32'(err_cnt), cnt_m);
      cyc = 1'b0; stb = 1'b0;
      tick();
      check("err_single", 32'(err), 0);
      return;
    end
    oh = NS'(1) << (page - 1);
    for (int n = 0; n <= wait_cyc; n++) begin
      check("req_stb",   32'(s_stb), 32'(oh));
      check("req_cyc",   32'(s_cyc), 1);
      check("req_adr",   32'(s_adr), a & 32'hF);
      check("req_we",    32'(s_we), 32'(w));
      check("req_datwr", s_datwr, d);
      check("req_noack", 32'(ack), 0);
      check("req_noerr", 32'(err), 0);
      s_ack = NS'($urandom) & ~oh;
      if (n == wait_cyc) s_ack = s_ack | oh;
      tick();
    end
    s_ack = '0;
    check("resp_ack",   32'(ack), 1);
    check("resp_data",  datrd, slv_data[page-1]);
    check("resp_noerr", 32'(err), 0);
    check("resp_nostb", 32'(s_stb), 0);
    check("resp_nocyc", 32'(s_cyc), 0);
    cyc = 1'b0; stb = 1'b0;
    tick();
    check("ack_single", 32'(ack), 0);
    check("datrd_hold", datrd, slv_data[page-1]);
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; datwr = '0;
    s_ack = '0; s_datrd = '0;
    for (int k = 0; k < NS; k++) slv_data[k] = $urandom;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack",   32'(ack), 0);
    check("rst_err",   32'(err), 0);
    check("rst_stb",   32'(s_stb), 0);
    check("rst_cyc",   32'(s_cyc), 0);
    check("rst_datrd", datrd, 0);
    check("rst_ecnt",  32'(err_cnt), 0);
    rst = 1'b0;
    tick();

    // Directed read of 0x24 from slave 1, zero wait
    slv_data[1] = 32'hCAFEF00D;
    access(32'h24, 1'b0, 32'h0, 0);
    // Directed write to 0x48, slave 3, three wait cycles
    access(32'h48, 1'b1, 32'h12345678, 3);
    // Unmapped pages
    access(32'h00, 1'b0, 32'h0, 0);
    access(32'h5C, 1'b1, 32'h1, 0);
    check("dir_eadr", err_adr, 32'h5C);
    check("dir_ecnt", 32'(err_cnt), 2);

    // Host drops cyc mid-REQ
    load_slaves();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h1C; datwr = '0;
    tick();
    tick();
    tick();
    cyc = 1'b0; stb = 1'b0;
    tick();
    check("abort_stb", 32'(s_stb), 0);
    check("abort_cyc", 32'(s_cyc), 0);
    check("abort_ack", 32'(ack), 0);
    check("abort_err", 32'(err), 0);
    tick();
    check("abort_ack2", 32'(ack), 0);
    check("abort_err2", 32'(err), 0);

    // Asynchronous reset mid-REQ
    cyc = 1'b1; stb = 1'b1; adr = 32'h31;
    tick();
    #2 rst = 1'b1;
    #1;
    check("arst_stb",   32'(s_stb), 0);
    check("arst_cyc",   32'(s_cyc), 0);
    check("arst_adr",   32'(s_adr), 0);
    check("arst_ack",   32'(ack), 0);
    check("arst_err",   32'(err), 0);
    check("arst_datrd", datrd, 0);
    check("arst_eadr",  err_adr, 0);
    check("arst_ecnt",  32'(err_cnt), 0);
    cnt_m = 0; eadr_m = '0;
    cyc = 1'b0; stb = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_ack", 32'(ack), 0);

`ifdef WFG_WB_INTERCONNECT_TIMEOUT_EN
    // Slave never acks: error after TMO cycles in REQ
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h10;
    tick();
    for (int n = 0; n < TMO; n++) begin
      check("tmo_wait_err", 32'(err), 0);
      check("tmo_wait_stb", 32'(s_stb), 1);
      tick();
    end
    if (cnt_m < 255) cnt_m++;
    check("tmo_err",  32'(err), 1);
    check("tmo_stb",  32'(s_stb), 0);
    check("tmo_eadr", err_adr, 32'h10);
    check("tmo_ecnt", 32'(err_cnt), cnt_m);
    eadr_m = 32'h10;
    cyc = 1'b0; stb = 1'b0;
    tick();
    // Ack on the expiry cycle wins
    access(32'h20, 1'b0, 32'h0, TMO - 1);
`endif

    // Randomized traffic
    for (int t = 0; t < 150; t++) begin
      logic [31:0] a;
      for (int k = 0; k < NS; k++) slv_data[k] = $urandom;
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = (32'($urandom_range(0, NS + 2)) << PLSB) | 32'($urandom_range(0, 15));
      access(a, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 6));
    end

    // Saturation of the fault counter
    for (int t = 0; t < 300; t++) begin
      access(32'($urandom_range(NS + 1, 200)) << PLSB, 1'b0, 32'h0, 0);
    end
    check("sat_cnt", 32'(err_cnt), 255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
